alu_mc: RTL and testbench

- Parametrised, handshaked successor to the single-cycle EX-stage ALU.
- Adds registered outputs, a full flag set, shifts, signed/unsigned compare, and iterative multiply/divide (one bit per cycle).
- Sits in the EX stage of the pipelined CPU. The hazard unit stalls the pipeline on in_ready/out_valid.
- The operand-B immediate mux stays inside the block.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_mc.sv | 170 +++++++++++++++++
 tb/tb_alu_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle EX-stage ALU.
//   alu_op_e    - 4-bit opcode encoding (OP_* members)
//   alu_state_e - control FSM states
//   is_muldiv / is_div / is_signed_md - opcode class helpers
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_SRL   = 4'b1001,
    OP_SRA   = 4'b1010,
    OP_RSVD  = 4'b1011,
    OP_MULT  = 4'b1100,
    OP_MULTU = 4'b1101,
    OP_DIV   = 4'b1110,
    OP_DIVU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(alu_op_e op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_div(alu_op_e op);
    return op[3:1] == 3'b111;
  endfunction

  // MULT/DIV are even opcodes, MULTU/DIVU odd
  function automatic logic is_signed_md(alu_op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply/divide engine, one bit per cycle.
//   start     - load operands and begin (WIDTH iterations follow)
//   abort     - drop an in-flight operation
//   is_signed - treat a/b as two's complement
//   is_div    - 1: restoring divide, 0: shift-add multiply
//   done      - high during the final iteration cycle
//   lo / hi   - low product / quotient, high product / remainder
// Works on magnitudes; sign correction is applied on the output side so the
// iteration datapath stays unsigned.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q, div_q, neg_lo_q, neg_hi_q;
  logic [CNT_W-1:0] cnt_q;
  // acc: high product / partial remainder; mq: multiplier / quotient bits;
  // mag: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, mq_q, mag_q;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_trial;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_n;

  assign sa    = is_signed && a[WIDTH-1];
  assign sb    = is_signed && b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mag_q} : '0);
  assign div_sh    = {acc_q, mq_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, mag_q};
  // partial remainder < divisor, so a real borrow always lands in the top bit
  assign div_ok    = !div_trial[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      mag_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(WIDTH-1);
      div_q    <= is_div;
      neg_lo_q <= sa ^ sb;
      neg_hi_q <= sa;
      acc_q    <= '0;
      mq_q     <= is_div ? mag_a : mag_b;
      mag_q    <= is_div ? mag_b : mag_a;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      if (div_q) begin
        acc_q <= div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
        mq_q  <= {mq_q[WIDTH-2:0], div_ok};
      end else begin
        acc_q <= mul_sum[WIDTH:1];
        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign done   = busy_q && (cnt_q == '0);
  assign prod   = {acc_q, mq_q};
  assign prod_n = -prod;

  always_comb begin
    if (div_q) begin
      lo = neg_lo_q ? -mq_q  : mq_q;
      hi = neg_hi_q ? -acc_q : acc_q;
    end else begin
      lo = neg_lo_q ? prod_n[WIDTH-1:0]       : mq_q;
      hi = neg_lo_q ? prod_n[2*WIDTH-1:WIDTH] : acc_q;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle EX-stage ALU.
//   clk, rst_n          - clock, async active-low reset
//   kill                - abort in-flight op / block acceptance (branch flush)
//   in_valid/in_ready   - operation handshake; op, a, b_reg, imm, src_imm
//   out_valid/out_ready - result handshake; result, hi, zero, ovf, divz, illegal
// Build option: define ALU_MC_MULDIV_EN to include the iterative
// multiply/divide engine; otherwise opcodes 11xx are reserved (illegal).
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_reg,
  input  logic [WIDTH-1:0] imm,
  input  logic             src_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             divz,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic             ovf;
    logic             divz;
    logic             ill;
  } alu_out_t;

  alu_state_e       state_q, state_d;
  alu_out_t         out_q, out_d;
  alu_op_e          op_e;
  logic [WIDTH-1:0] b, add_res, sub_res;
  logic [SHAMT_W-1:0] shamt;
  logic             accept;

  assign op_e    = alu_op_e'(op);
  assign b       = src_imm ? imm : b_reg;
  assign shamt   = b[SHAMT_W-1:0];
  assign add_res = a + b;
  assign sub_res = a - b;
  assign accept  = (state_q == IDLE) && in_valid && !kill;

`ifdef ALU_MC_MULDIV_EN
  logic             md_go, md_start, md_sel_q, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  // divide by zero short-circuits to a 1-cycle result
  assign md_go    = is_muldiv(op_e) && !(is_div(op_e) && (b == '0));
  assign md_start = accept && md_go;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .abort    (kill),
    .is_signed(is_signed_md(op_e)),
    .is_div   (is_div(op_e)),
    .a        (a),
    .b        (b),
    .done     (eng_done),
    .lo       (eng_lo),
    .hi       (eng_hi)
  );
`endif

  // single-cycle result, captured at acceptance
  always_comb begin
    out_d = '0;
    case (op_e)
      OP_AND:  out_d.res = a & b;
      OP_OR:   out_d.res = a | b;
      OP_ADD: begin
        out_d.res = add_res;
        out_d.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  out_d.res = a ^ b;
      OP_NOR:  out_d.res = ~(a | b);
      OP_SLL:  out_d.res = a << shamt;
      OP_SUB: begin
        out_d.res = sub_res;
        out_d.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  out_d.res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: out_d.res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SRL:  out_d.res = a >> shamt;
      OP_SRA:  out_d.res = $signed(a) >>> shamt;
`ifdef ALU_MC_MULDIV_EN
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        if (is_div(op_e) && (b == '0)) begin
          out_d.res  = '1;
          out_d.hi   = a;
          out_d.divz = 1'b1;
        end
      end
`endif
      default: out_d.ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MC_MULDIV_EN
          state_d = md_go ? BUSY : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_MC_MULDIV_EN
      BUSY: begin
        if (kill)          state_d = IDLE;
        else if (eng_done) state_d = DONE;
      end
`endif
      DONE: begin
        if (kill || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
`ifdef ALU_MC_MULDIV_EN
      md_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_q <= out_d;
`ifdef ALU_MC_MULDIV_EN
        md_sel_q <= md_go;
`endif
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
`ifdef ALU_MC_MULDIV_EN
  // engine registers hold their final value through DONE
  assign result = md_sel_q ? eng_lo : out_q.res;
  assign hi     = md_sel_q ? eng_hi : out_q.hi;
`else
  assign result = out_q.res;
  assign hi     = out_q.hi;
`endif
  assign zero    = out_valid && (result == '0);
  assign ovf     = out_q.ovf;
  assign divz    = out_q.divz;
  assign illegal = out_q.ill;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int W = 32;
`ifdef ALU_MC_MULDIV_EN
  localparam int MDLAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         kill = 1'b0, in_valid = 1'b0, out_ready = 1'b0, src_imm = 1'b0;
  logic         in_ready, out_valid, zero, ovf, divz, illegal;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b_reg = '0, imm = '0, result, hi;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b_reg(b_reg), .imm(imm), .src_imm(src_imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
    .zero(zero), .ovf(ovf), .divz(divz), .illegal(illegal)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, imm;
    logic         src;
    logic [W-1:0] res, hi;
    logic         ovf, divz, ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] o, logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] vi, logic s, logic [W-1:0] r, logic [W-1:0] h,
                              logic v, logic dz, logic il, int l);
    vec_t t;
    t.op = o; t.a = va; t.b = vb; t.imm = vi; t.src = s;
    t.res = r; t.hi = h; t.ovf = v; t.divz = dz; t.ill = il; t.lat = l;
    return t;
  endfunction

  // Reference model: plain integer arithmetic on the architectural rules
  function automatic vec_t model(logic [3:0] o, logic [W-1:0] va, logic [W-1:0] vbr,
                                 logic [W-1:0] vi, logic s);
    vec_t t;
    logic [W-1:0] vb;
    longint sa, sb, x, d, q;
    logic [63:0] pu;
    int sh;
    vb = s ? vi : vbr;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    sh = int'(vb[4:0]);
    t = mk(o, va, vbr, vi, s, '0, '0, 1'b0, 1'b0, 1'b0, 1);
    case (o)
      4'd0: t.res = va & vb;
      4'd1: t.res = va | vb;
      4'd2: begin
        x = sa + sb; t.res = x[W-1:0];
        t.ovf = (x > 64'sd2147483647) || (x < -64'sd2147483648);
      end
      4'd3: t.res = va ^ vb;
      4'd4: t.res = ~(va | vb);
      4'd5: begin pu = {32'd0, va} * (64'd1 << sh); t.res = pu[W-1:0]; end
      4'd6: begin
        x = sa - sb; t.res = x[W-1:0];
        t.ovf = (x > 64'sd2147483647) || (x < -64'sd2147483648);
      end
      4'd7: t.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: t.res = (va < vb) ? 32'd1 : 32'd0;
      4'd9: begin pu = {32'd0, va} / (64'd1 << sh); t.res = pu[W-1:0]; end
      4'd10: begin
        d = longint'(1) << sh;
        q = sa / d;
        if (sa < 0 && q * d != sa) q = q - 1;
        t.res = q[W-1:0];
      end
`ifdef ALU_MC_MULDIV_EN
      4'd12: begin x = sa * sb; t.res = x[W-1:0]; t.hi = x[63:32]; t.lat = MDLAT; end
      4'd13: begin pu = {32'd0, va} * {32'd0, vb}; t.res = pu[W-1:0]; t.hi = pu[63:32]; t.lat = MDLAT; end
      4'd14, 4'd15: begin
        if (vb == '0) begin
          t.res = '1; t.hi = va; t.divz = 1'b1;
        end else begin
          t.lat = MDLAT;
          if (o == 4'd14) begin
            q = sa / sb; x = sa % sb;
            t.res = q[W-1:0]; t.hi = x[W-1:0];
          end else begin
            t.res = va / vb; t.hi = va % vb;
          end
        end
      end
`endif
      default: t.ill = 1'b1;
    endcase
    return t;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat, busy;
    @(negedge clk);
    op = v.op; a = v.a; b_reg = v.b; imm = v.imm; src_imm = v.src; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0; busy = 0;
    do begin
      @(negedge clk); lat++;
      if (!out_valid && !in_ready) busy++;
    end while (!out_valid && lat < 100);
    chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
    chk({tag, ".busy"}, 32'(busy), 32'(v.lat - 1));
    chk({tag, ".result"}, result, v.res);
    chk({tag, ".hi"}, hi, v.hi);
    chk({tag, ".flags"}, {28'd0, zero, ovf, divz, illegal},
        {28'd0, v.res == '0, v.ovf, v.divz, v.ill});
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".outs"}, {result[15:0], hi[9:0], out_valid, zero, ovf, divz, illegal, 1'b0},
        32'd0);
  endtask

  initial begin
    vec_t v;
    int cnt;
    // directed table
    vecs.push_back(mk(4'd2,  32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 32'h80000000, 0, 1, 0, 0, 1));
    vecs.push_back(mk(4'd6,  32'd5, 32'd123, 32'd5, 1'b1, 32'd0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd10, 32'h80000000, 32'h24, 32'd0, 1'b0, 32'hF8000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd7,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd8,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd11, 32'h12345678, 32'd9, 32'd0, 1'b0, 32'd0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'h00F000F0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd4,  32'd0, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd5,  32'd1, 32'h21, 32'd0, 1'b0, 32'd2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'd6,  32'h80000000, 32'd0, 32'd1, 1'b1, 32'h7FFFFFFF, 0, 1, 0, 0, 1));
`ifdef ALU_MC_MULDIV_EN
    vecs.push_back(mk(4'd12, 32'hFFFFFFFD, 32'd7, 32'd0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, 33));
    vecs.push_back(mk(4'd13, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 32'hFFFFFFFE, 32'd1, 0, 0, 0, 33));
    vecs.push_back(mk(4'd14, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 33));
    vecs.push_back(mk(4'd15, 32'd9, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd9, 0, 1, 0, 1));
    vecs.push_back(mk(4'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h80000000, 32'd0, 0, 0, 0, 33));
`else
    vecs.push_back(mk(4'd12, 32'hFFFFFFFD, 32'd7, 32'd0, 1'b0, 32'd0, 32'd0, 0, 0, 1, 1));
    vecs.push_back(mk(4'd15, 32'd9, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 0, 0, 1, 1));
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk_quiet("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // randomized against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rb;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 40));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1)
        v = model(4'($urandom_range(0, 15)), $urandom, $urandom, rb, 1'b1);
      else
        v = model(4'($urandom_range(0, 15)), $urandom, rb, $urandom, 1'b0);
      run_op(v, $sformatf("rnd%0d_op%0d", i, v.op));
    end

    // backpressure: hold result 5 cycles, then offer next op during the DONE cycle
    @(negedge clk);
    op = 4'd2; a = 32'd3; b_reg = 32'd4; src_imm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp.first", {30'd0, out_valid, in_ready}, 32'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d", i), {result[29:0], out_valid, in_ready}, {30'd7, 2'b10});
    end
    out_ready = 1'b1; op = 4'd1; a = 32'd1; b_reg = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp.release", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp.next", {result[29:0], out_valid, in_ready}, {30'd3, 2'b10});
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // kill in DONE drops the result
    @(negedge clk);
    op = 4'd3; a = 32'h55; b_reg = 32'hAA; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("kdone.valid", 32'(out_valid), 32'd1);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 kill = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("kdone.after", {30'd0, out_valid, in_ready}, 32'b01);

    // kill in IDLE blocks acceptance
    kill = 1'b1; in_valid = 1'b1; op = 4'd2;
    @(posedge clk); #1 kill = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("kidle", {30'd0, out_valid, in_ready}, 32'b01);

`ifdef ALU_MC_MULDIV_EN
    // kill at BUSY cycle 10 of DIVU
    op = 4'd15; a = 32'd100; b_reg = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("kbusy.busy", {30'd0, out_valid, in_ready}, 32'b00);
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    chk("kbusy.idle", {30'd0, out_valid, in_ready}, 32'b01);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("kbusy.noresult", 32'(cnt), 32'd0);
    run_op(model(4'd15, 32'd100, 32'd7, 32'd0, 1'b0), "kbusy.rerun");

    // reset mid-MULT
    @(negedge clk);
    op = 4'd12; a = 32'hFFFFFFFD; b_reg = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);
`else
    // reset while holding a result with ovf set
    @(negedge clk);
    op = 4'd2; a = 32'h7FFFFFFF; b_reg = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pre", {30'd0, out_valid, ovf}, 32'b11);
`endif
    rst_n = 1'b0;
    #1;
    chk_quiet("rst.mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.after", {30'd0, out_valid, in_ready}, 32'b01);
    run_op(model(4'd2, 32'd10, 32'd20, 32'd0, 1'b0), "rst.next");

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
